commit_trace_fifo: RTL

COMMIT_TRACE_FIFO -- requirements
Module: commit_trace_fifo

---
 rtl/commit_trace_fifo_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 99 +++++++++
 rtl/commit_trace_fifo.sv | 109 ++++++++++
 3 files changed

// File: rtl/commit_trace_fifo_pkg.sv
// Shared types for the commit trace FIFO: retired-instruction record,
// capture FSM state encoding and record width.
package commit_trace_fifo_pkg;

  // One retired instruction as seen at writeback
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] rd_wdata;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
  } commit_rec_t;

  localparam int unsigned REC_W = $bits(commit_rec_t);

  // Capture FSM; code 3 is unused and recovers to ST_IDLE
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } trace_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head output.
// Ports:
//   clk, rst       clock, async active-high reset (clears all pointers/flags)
//   push_i/wdata_i write request and data; accepted when not full or when
//                  a pop happens in the same cycle
//   pop_i          remove head; ignored when empty
//   full_o/empty_o registered occupancy flags
//   count_o        registered number of entries held
//   rdata_o        registered head entry, valid while !empty_o
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [WIDTH-1:0]           rdata_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push_ok, pop_ok;
  logic [PTR_W-1:0] rd_ptr_inc;

  assign pop_ok     = pop_i && !empty_q;
  assign push_ok    = push_i && (!full_q || pop_ok);
  assign rd_ptr_inc = rd_ptr_q + PTR_W'(1);

  // Pointer/count/head next-state; DEPTH is a power of two so pointers wrap
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_inc;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Head register tracks the entry at rd_ptr; the incoming word becomes
    // head only when the slot it lands in is the next head.
    if (pop_ok) begin
      if (count_q == CNT_W'(1)) begin
        if (push_ok) head_d = wdata_i;
      end else begin
        head_d = mem_q[rd_ptr_inc];
      end
    end else if (empty_q && push_ok) begin
      head_d = wdata_i;
    end
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == CNT_W'(0));
  end

  // Control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      head_q   <= head_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;
  assign rdata_o = head_q;

endmodule

// File: rtl/commit_trace_fifo.sv
// Commit trace capture buffer: records retired instructions between a
// start and stop pulse, then drains them to a model-side consumer.
// Ports:
//   clk, rst          clock, async active-high reset
//   start, stop       capture window control pulses
//   wb_valid, wb_rec  retired-instruction record from writeback
//   out_valid/ready   head handshake to consumer; out_rec is the head
//   count             records held
//   overflow          sticky: a record was dropped while full
//   drop_cnt          dropped records, saturating
//   state             FSM state (0 idle, 1 capture, 2 drain)
module commit_trace_fifo
  import commit_trace_fifo_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DROP_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       wb_valid,
  input  commit_rec_t                wb_rec,
  output logic                       out_valid,
  input  logic                       out_ready,
  output commit_rec_t                out_rec,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_cnt,
  output logic [1:0]                 state
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  trace_state_e      state_q, state_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [REC_W-1:0]  fifo_rdata;
  logic              push_req, push, pop, drop;

  // A full FIFO still takes a record when the head leaves the same cycle
  assign pop      = !fifo_empty && out_ready;
  assign push_req = (state_q == ST_CAPTURE) && wb_valid;
  assign push     = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (wb_rec),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .rdata_o (fifo_rdata)
  );

  // Capture FSM and drop accounting
  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    case (state_q)
      ST_IDLE: begin
        // start wins over a coincident stop
        if (start) begin
          state_d    = ST_CAPTURE;
          overflow_d = 1'b0;
          drop_cnt_d = '0;
        end
      end
      ST_CAPTURE: if (stop) state_d = ST_DRAIN;
      ST_DRAIN:   if (fifo_empty && !pop) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    // Drops only occur in CAPTURE, so never collide with the clear above
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_valid = !fifo_empty;
  assign out_rec   = commit_rec_t'(fifo_rdata);
  assign count     = fifo_count;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign state     = state_q;

endmodule
